// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: request, mem and response bundle of the arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_req_arbiter_if #(
  parameter int AddrWidth   = 32,
  parameter int MemTidWidth = 2
);
  logic [1:0]                  req_valid_i;
  logic [1:0]                  req_ready_o;
  logic [1:0][AddrWidth-1:0]   req_addr_i;
  logic [1:0][MemTidWidth-1:0] req_tid_i;
  logic                        mem_valid_o;
  logic                        mem_ready_i;
  logic [AddrWidth-1:0]        mem_addr_o;
  logic [MemTidWidth:0]        mem_tid_o;
  logic                        rsp_valid_i;
  logic [MemTidWidth:0]        rsp_tid_i;
  logic [1:0]                  rsp_valid_o;
  logic [MemTidWidth-1:0]      rsp_tid_o;
  logic [1:0][3:0]             outstanding_o;
  logic                        err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_tid_i,
    input  mem_ready_i, rsp_valid_i, rsp_tid_i,
    output req_ready_o, mem_valid_o, mem_addr_o,
    output mem_tid_o, rsp_valid_o, rsp_tid_o,
    output outstanding_o, err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_tid_i,
    output mem_ready_i, rsp_valid_i, rsp_tid_i,
    input  req_ready_o, mem_valid_o, mem_addr_o,
    input  mem_tid_o, rsp_valid_o, rsp_tid_o,
    input  outstanding_o, err_o
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin icache(0)/dcache(1) to mem arbiter with
// per-source in-flight limits and response routing. Ports: clk_i, rst_i, bus.
module mem_req_arbiter #(
  parameter int AddrWidth      = 32,
  parameter int MemTidWidth    = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_req_arbiter_if.slave   bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);

  logic [0:0]             state_q;
  logic                   ptr_q;
  logic                   src_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [MemTidWidth-1:0] tid_q;
  logic [1:0][3:0]        cnt_q;
  logic                   err_q;

  logic [1:0] elig;
  logic [1:0] inc;
  logic [1:0] hit;
  logic [1:0] dec;
  logic       underflow;
  logic       gnt_any;
  logic       gnt_src;
  logic       hs;
  logic       rsp_src;

  assign rsp_src = bus.rsp_tid_i[MemTidWidth];
  assign hs      = (state_q == HOLD) && bus.mem_ready_i;

  always_comb begin
    elig      = '0;
    inc       = '0;
    hit       = '0;
    dec       = '0;
    underflow = 1'b0;
    for (int s = 0; s < 2; s++) begin
      elig[s] = bus.req_valid_i[s] && (cnt_q[s] < MaxCnt);
      inc[s]  = hs && (src_q == 1'(s));
      hit[s]  = bus.rsp_valid_i && (rsp_src == 1'(s));
      dec[s]  = hit[s] && (cnt_q[s] != 4'd0);
      if (hit[s] && (cnt_q[s] == 4'd0))
        underflow = 1'b1;
    end
  end

  // ptr_q names the favoured source when both are eligible.
  assign gnt_any = !rst_i && (state_q == IDLE) && (|elig);
  assign gnt_src = elig[1] && (!elig[0] || ptr_q);

  assign bus.req_ready_o   = {gnt_any & gnt_src, gnt_any & ~gnt_src};
  assign bus.mem_valid_o   = (state_q == HOLD);
  assign bus.mem_addr_o    = addr_q;
  assign bus.mem_tid_o     = {src_q, tid_q};
  assign bus.rsp_valid_o   = hit;
  assign bus.rsp_tid_o     = bus.rsp_tid_i[MemTidWidth-1:0];
  assign bus.outstanding_o = cnt_q;
  assign bus.err_o         = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      src_q   <= 1'b0;
      addr_q  <= '0;
      tid_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (gnt_any) begin
          addr_q  <= bus.req_addr_i[gnt_src];
          tid_q   <= bus.req_tid_i[gnt_src];
          src_q   <= gnt_src;
          state_q <= HOLD;
        end
      end else if (bus.mem_ready_i) begin
        state_q <= IDLE;
        ptr_q   <= ~src_q;
      end
      for (int s = 0; s < 2; s++) begin
        if (inc[s] && !dec[s])
          cnt_q[s] <= cnt_q[s] + 4'd1;
        else if (dec[s] && !inc[s])
          cnt_q[s] <= cnt_q[s] - 4'd1;
      end
      err_q <= err_q | underflow;
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_mem_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_req_arbiter_if #(.AddrWidth(32), .MemTidWidth(2)) bus ();

  mem_req_arbiter #(
    .AddrWidth(32), .MemTidWidth(2), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] tid;
    logic [1:0] exp_v;
    logic [1:0] exp_tid;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [1:0]  t;
  } pend_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic s, input logic [31:0] a,
                        input logic [1:0] t);
    bus.req_valid_i    = 2'b00;
    bus.req_valid_i[s] = 1'b1;
    bus.req_addr_i[s]  = a;
    bus.req_tid_i[s]   = t;
    #1;
    chk("do_req grant", bus.req_ready_o, (s ? 2'b10 : 2'b01));
    tick();
    bus.req_valid_i = 2'b00;
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
  endtask

  int         cnt[2];
  logic       m_err;
  logic       last;
  pend_t      pend[$];
  logic [1:0] infl0[$];
  logic [1:0] infl1[$];

  initial begin
    vecs[0] = '{1'b0, 3'b101, 2'b00, 2'b01, 1'b0};
    vecs[1] = '{1'b0, 3'b000, 2'b00, 2'b00, 1'b0};
    vecs[2] = '{1'b1, 3'b000, 2'b01, 2'b00, 1'b1};
    vecs[3] = '{1'b0, 3'b111, 2'b00, 2'b11, 1'b1};
    vecs[4] = '{1'b1, 3'b110, 2'b10, 2'b10, 1'b1};
    vecs[5] = '{1'b1, 3'b011, 2'b01, 2'b11, 1'b1};

    bus.req_valid_i = 2'b11;
    bus.req_addr_i  = '0;
    bus.req_tid_i   = '0;
    bus.mem_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b0;
    bus.rsp_tid_i   = '0;

    // reset state
    tick();
    chk("rst mem_valid", bus.mem_valid_o, 0);
    chk("rst req_ready", bus.req_ready_o, 0);
    chk("rst outst", bus.outstanding_o, 0);
    chk("rst err", bus.err_o, 0);
    chk("rst addr", bus.mem_addr_o, 0);
    chk("rst tid", bus.mem_tid_o, 0);
    bus.req_valid_i = 2'b00;
    rst = 1'b0;
    tick();

    // response routing table, including underflow error
    for (int i = 0; i < 6; i++) begin
      bus.rsp_valid_i = vecs[i].v;
      bus.rsp_tid_i   = vecs[i].tid;
      #1;
      chk($sformatf("vec%0d rsp_v", i), bus.rsp_valid_o, vecs[i].exp_v);
      chk($sformatf("vec%0d rsp_t", i), bus.rsp_tid_o, vecs[i].exp_tid);
      tick();
      chk($sformatf("vec%0d err", i), bus.err_o, vecs[i].exp_err);
      chk($sformatf("vec%0d cnt", i), bus.outstanding_o, 0);
    end
    bus.rsp_valid_i = 1'b0;

    // hold with mem stalled 5 cycles
    bus.req_valid_i   = 2'b01;
    bus.req_addr_i[0] = 32'h8000_0000;
    bus.req_tid_i[0]  = 2'b01;
    #1;
    chk("stall grant", bus.req_ready_o, 2'b01);
    tick();
    bus.req_valid_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("stall valid", bus.mem_valid_o, 1);
      chk("stall addr", bus.mem_addr_o, 32'h8000_0000);
      chk("stall tid", bus.mem_tid_o, 3'b001);
      chk("stall ready", bus.req_ready_o, 0);
      tick();
    end
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    chk("stall done valid", bus.mem_valid_o, 0);
    chk("stall done cnt0", bus.outstanding_o[0], 1);

    // source 1 fills to the limit
    for (int i = 0; i < 4; i++)
      do_req(1'b1, 32'h1000 + 32'(i * 4), 2'(i));
    chk("full cnt1", bus.outstanding_o[1], 4);
    bus.req_valid_i = 2'b10;
    #1;
    chk("full blocked", bus.req_ready_o, 2'b00);
    bus.req_valid_i   = 2'b11;
    bus.req_addr_i[0] = 32'h2000;
    #1;
    chk("full skip", bus.req_ready_o, 2'b01);
    tick();
    bus.req_valid_i = 2'b00;
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    chk("full cnt0", bus.outstanding_o[0], 2);
    bus.rsp_valid_i = 1'b1;
    bus.rsp_tid_i   = 3'b110;
    #1;
    chk("full rsp_v", bus.rsp_valid_o, 2'b10);
    chk("full rsp_t", bus.rsp_tid_o, 2'b10);
    tick();
    bus.rsp_valid_i = 1'b0;
    chk("full cnt1 dec", bus.outstanding_o[1], 3);

    // handshake and response on source 0 together
    bus.req_valid_i = 2'b01;
    tick();
    bus.req_valid_i = 2'b00;
    bus.mem_ready_i = 1'b1;
    bus.rsp_valid_i = 1'b1;
    bus.rsp_tid_i   = 3'b000;
    #1;
    chk("same valid", bus.mem_valid_o, 1);
    tick();
    bus.mem_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b0;
    chk("same cnt0", bus.outstanding_o[0], 2);
    chk("err sticky", bus.err_o, 1);

    // reset in hold
    bus.req_valid_i = 2'b10;
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    chk("mid hold", bus.mem_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("mid rst valid", bus.mem_valid_o, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post rst cnt", bus.outstanding_o, 0);
    chk("post rst err", bus.err_o, 0);
    chk("post rst valid", bus.mem_valid_o, 0);

    // both sources streaming
    begin
      logic       rv;
      logic [2:0] rt;
      rv = 1'b0;
      rt = '0;
      bus.req_valid_i   = 2'b11;
      bus.req_addr_i[0] = 32'hA0;
      bus.req_addr_i[1] = 32'hB0;
      bus.mem_ready_i   = 1'b1;
      for (int i = 0; i < 8; i++) begin
        bus.rsp_valid_i = rv;
        bus.rsp_tid_i   = rt;
        #1;
        if (i % 2 == 0) begin
          chk("rr grant", bus.req_ready_o,
              ((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
        end else begin
          chk("rr hold", bus.req_ready_o, 2'b00);
          chk("rr src", bus.mem_tid_o[2], ((i / 2) % 2));
        end
        rv = bus.mem_valid_o & bus.mem_ready_i;
        rt = bus.mem_tid_o;
        tick();
      end
      bus.req_valid_i = 2'b00;
      bus.mem_ready_i = 1'b0;
      bus.rsp_valid_i = rv;
      bus.rsp_tid_i   = rt;
      tick();
      bus.rsp_valid_i = 1'b0;
      tick();
      chk("rr cnt", bus.outstanding_o, 0);
      chk("rr err", bus.err_o, 0);
    end

    // randomized run against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    m_err  = 1'b0;
    last   = 1'b1;
    for (int c = 0; c < 600; c++) begin
      logic       e0, e1, win, rs, ok;
      logic [2:0] tg;
      logic [1:0] ev;
      bus.req_valid_i   = 2'($urandom);
      bus.req_addr_i[0] = $urandom;
      bus.req_addr_i[1] = $urandom;
      bus.req_tid_i[0]  = 2'($urandom);
      bus.req_tid_i[1]  = 2'($urandom);
      bus.mem_ready_i   = ($urandom_range(0, 9) < 7);
      bus.rsp_valid_i   = 1'b0;
      tg = 3'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        rs = 1'($urandom);
        ok = 1'b1;
        if (rs == 1'b0 && infl0.size() == 0) rs = 1'b1;
        if (rs == 1'b1 && infl1.size() == 0) rs = 1'b0;
        if (rs == 1'b0 && infl0.size() != 0)
          tg = {1'b0, infl0.pop_front()};
        else if (rs == 1'b1 && infl1.size() != 0)
          tg = {1'b1, infl1.pop_front()};
        else
          ok = ($urandom_range(0, 15) == 0);
        bus.rsp_valid_i = ok;
      end
      bus.rsp_tid_i = tg;
      #1;
      ev = '0;
      win = 1'b0;
      e0 = bus.req_valid_i[0] && cnt[0] < 4;
      e1 = bus.req_valid_i[1] && cnt[1] < 4;
      if (pend.size() == 0) begin
        if (e0 && e1) win = ~last;
        else win = e1;
        if (e0 || e1) ev = win ? 2'b10 : 2'b01;
        chk("rnd ready", bus.req_ready_o, ev);
        chk("rnd mvalid", bus.mem_valid_o, 0);
      end else begin
        chk("rnd ready", bus.req_ready_o, 0);
        chk("rnd mvalid", bus.mem_valid_o, 1);
        chk("rnd maddr", bus.mem_addr_o, pend[0].a);
        chk("rnd mtid", bus.mem_tid_o, {pend[0].s, pend[0].t});
      end
      chk("rnd rsp_v", bus.rsp_valid_o,
          bus.rsp_valid_i ? (tg[2] ? 2'b10 : 2'b01) : 2'b00);
      chk("rnd rsp_t", bus.rsp_tid_o, tg[1:0]);
      chk("rnd cnt0", bus.outstanding_o[0], cnt[0]);
      chk("rnd cnt1", bus.outstanding_o[1], cnt[1]);
      chk("rnd err", bus.err_o, m_err);
      // advance model to the next edge
      if (bus.rsp_valid_i) begin
        if (cnt[tg[2]] == 0) m_err = 1'b1;
        else cnt[tg[2]] = cnt[tg[2]] - 1;
      end
      if (pend.size() == 0) begin
        if (e0 || e1)
          pend.push_back('{win, bus.req_addr_i[win],
                           bus.req_tid_i[win]});
      end else if (bus.mem_ready_i) begin
        cnt[pend[0].s] = cnt[pend[0].s] + 1;
        if (pend[0].s) infl1.push_back(pend[0].t);
        else infl0.push_back(pend[0].t);
        last = pend[0].s;
        void'(pend.pop_front());
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
